// File: rtl/bus_master_if.sv
// Request/response handshake between the memory-access stage
// and the bus master.
interface bus_master_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/bus_master.sv
// Single-outstanding bus master: CPU load/store requests become
// addr/data/ctrl bus cycles with a region-dependent wait window.
module bus_master #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int MEM_WAIT  = 2,
  parameter int DEV_WAIT  = 200,
  parameter int DEV_COUNT = 6
) (
  input  logic              clk,
  input  logic              rst,
  bus_master_if.master      req,
  output logic [ADDR_W-1:0] addr,
  inout  wire  [DATA_W-1:0] data,
  output logic              ctrl
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_e;

  localparam logic [9:0] MEM_LD = 10'(MEM_WAIT - 1);
  localparam logic [9:0] DEV_LD = 10'(DEV_WAIT - 1);

  state_e            state_q;
  logic              we_q;
  logic              dev_q;
  logic [DATA_W-1:0] wdata_q;
  logic [9:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              ctrl_q;
  logic              oe_q;
  logic              ready_q;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rerr_q;

  logic is_dev;
  logic is_err;

  assign is_dev = req.req_addr[15:8] == 8'hFF;
  assign is_err = is_dev &&
                  (32'(req.req_addr[7:4]) >= DEV_COUNT);

  assign addr          = addr_q;
  assign ctrl          = ctrl_q;
  assign data          = oe_q ? wdata_q : 'z;
  assign req.req_ready = ready_q;
  assign req.rsp_valid = rvalid_q;
  assign req.rsp_rdata = rdata_q;
  assign req.rsp_err   = rerr_q;

  // Transaction FSM; every bus and response output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      dev_q    <= 1'b0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      ctrl_q   <= 1'b0;
      oe_q     <= 1'b0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req.req_valid) begin
            we_q    <= req.req_we;
            wdata_q <= req.req_wdata;
            dev_q   <= is_dev;
            ready_q <= 1'b0;
            if (is_err) begin
              state_q  <= DONE;
              rvalid_q <= 1'b1;
              rerr_q   <= 1'b1;
              rdata_q  <= '0;
            end else begin
              state_q <= SETUP;
              addr_q  <= req.req_addr;
              ctrl_q  <= req.req_we;
              oe_q    <= req.req_we;
            end
          end
        end
        SETUP: begin
          cnt_q   <= dev_q ? DEV_LD : MEM_LD;
          state_q <= ACCESS;
        end
        ACCESS: begin
          if (cnt_q != 10'd0) begin
            cnt_q <= cnt_q - 10'd1;
          end else begin
            if (!we_q) rdata_q <= data;
            rerr_q   <= 1'b0;
            rvalid_q <= 1'b1;
            ctrl_q   <= 1'b0;
            oe_q     <= 1'b0;
            state_q  <= DONE;
          end
        end
        DONE: begin
          rvalid_q <= 1'b0;
          ready_q  <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master.sv
// Bench for bus_master: directed vector table, random traffic
// against a memory reference model, and multi-cycle corner cases.
module tb_bus_master;

  localparam int MW = 2;
  localparam int DW = 200;
  localparam int DC = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_master_if #(.ADDR_W(16), .DATA_W(8)) bif ();

  logic [15:0] addr;
  logic        ctrl;
  tri1  [7:0]  data;

  bus_master #(
    .ADDR_W(16), .DATA_W(8),
    .MEM_WAIT(MW), .DEV_WAIT(DW), .DEV_COUNT(DC)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (bif.master),
    .addr (addr),
    .data (data),
    .ctrl (ctrl)
  );

  // Bus-side memory/peripheral: answers reads when enabled,
  // captures writes while ctrl is high.
  logic [7:0] smem [0:65535];
  logic       rd_en;
  assign data = (rd_en && !ctrl) ? smem[addr] : 8'bz;
  always @(posedge clk) if (ctrl) smem[addr] <= data;

  // Reference model state.
  logic [7:0]  ref_mem [0:65535];
  logic [7:0]  last_rdata;
  logic [15:0] last_addr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [15:0] a;
    logic [7:0]  wd;
    logic        err;
    int          lat;
    logic [7:0]  rd;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic predict(input logic we, input logic [15:0] a,
                         input logic [7:0] wd,
                         output logic e_err, output int lat,
                         output logic [7:0] e_rd);
    logic dev;
    dev   = (a[15:8] == 8'hFF);
    e_err = dev && (int'(a[7:4]) >= DC);
    lat   = e_err ? 1 : (dev ? DW : MW) + 2;
    if (e_err)   e_rd = 8'h00;
    else if (we) e_rd = last_rdata;
    else         e_rd = ref_mem[a];
    if (!e_err && we) ref_mem[a] = wd;
    last_rdata = e_rd;
  endtask

  task automatic run_txn(input logic we, input logic [15:0] a,
                         input logic [7:0] wd, input logic e_err,
                         input int lat, input logic [7:0] e_rd,
                         input logic nv, input logic nwe,
                         input logic [15:0] na, input logic [7:0] nwd);
    logic [15:0] pa;
    logic [15:0] ea;
    pa = last_addr;
    ea = e_err ? pa : a;
    chk("ready_at_accept", 32'(bif.req_ready), 32'd1);
    bif.req_valid = 1'b1;
    bif.req_we    = we;
    bif.req_addr  = a;
    bif.req_wdata = wd;
    rd_en = !we && !e_err;
    step();
    bif.req_valid = nv;
    bif.req_we    = nwe;
    bif.req_addr  = na;
    bif.req_wdata = nwd;
    for (int c = 1; c <= lat; c++) begin
      chk("rsp_valid", 32'(bif.rsp_valid), 32'(c == lat));
      chk("ready_busy", 32'(bif.req_ready), 32'd0);
      chk("addr", 32'(addr), 32'(ea));
      if (c < lat) begin
        chk("ctrl", 32'(ctrl), 32'(we));
        if (we) chk("data_drive", 32'(data), 32'(wd));
      end else begin
        chk("ctrl_done", 32'(ctrl), 32'd0);
        chk("rsp_err", 32'(bif.rsp_err), 32'(e_err));
        if (!we || e_err)
          chk("rsp_rdata", 32'(bif.rsp_rdata), 32'(e_rd));
      end
      if (!rd_en && !(we && c < lat))
        chk("data_z", 32'(data), 32'hFF);
      step();
    end
    rd_en = 1'b0;
    chk("ready_after", 32'(bif.req_ready), 32'd1);
    chk("rsp_valid_after", 32'(bif.rsp_valid), 32'd0);
    if (!e_err) last_addr = a;
  endtask

  task automatic model_txn(input logic we, input logic [15:0] a,
                           input logic [7:0] wd);
    logic       e_err;
    int         lat;
    logic [7:0] e_rd;
    predict(we, a, wd, e_err, lat, e_rd);
    run_txn(we, a, wd, e_err, lat, e_rd, 1'b0, 1'b0, 16'h0, 8'h0);
  endtask

  initial begin
    logic        e_err;
    int          lat;
    logic [7:0]  e_rd;
    logic        rwe;
    logic [15:0] ra;
    logic [7:0]  rwd;
    int          pulses;

    for (int i = 0; i < 65536; i++) begin
      smem[i]    = 8'(i) ^ 8'(i >> 8);
      ref_mem[i] = 8'(i) ^ 8'(i >> 8);
    end
    smem[16'h0010] = 8'hA5; ref_mem[16'h0010] = 8'hA5;
    smem[16'hFF5F] = 8'h77; ref_mem[16'hFF5F] = 8'h77;
    smem[16'hFE60] = 8'h11; ref_mem[16'hFE60] = 8'h11;

    tbl[0] = '{1'b0, 16'h0010, 8'h00, 1'b0,   4, 8'hA5};
    tbl[1] = '{1'b1, 16'hFF00, 8'h3C, 1'b0, 202, 8'hA5};
    tbl[2] = '{1'b0, 16'hFF70, 8'h00, 1'b1,   1, 8'h00};
    tbl[3] = '{1'b0, 16'hFF00, 8'h00, 1'b0, 202, 8'h3C};
    tbl[4] = '{1'b0, 16'hFF5F, 8'h00, 1'b0, 202, 8'h77};
    tbl[5] = '{1'b0, 16'hFF60, 8'h00, 1'b1,   1, 8'h00};
    tbl[6] = '{1'b1, 16'h1234, 8'h5A, 1'b0,   4, 8'h00};
    tbl[7] = '{1'b0, 16'h1234, 8'h00, 1'b0,   4, 8'h5A};
    tbl[8] = '{1'b0, 16'hFE60, 8'h00, 1'b0,   4, 8'h11};

    rst           = 1'b1;
    rd_en         = 1'b0;
    bif.req_valid = 1'b0;
    bif.req_we    = 1'b0;
    bif.req_addr  = '0;
    bif.req_wdata = '0;
    last_rdata    = 8'h00;
    last_addr     = 16'h0000;
    step(); step(); step();

    chk("rst_ready", 32'(bif.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bif.rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(bif.rsp_err), 32'd0);
    chk("rst_rsp_rdata", 32'(bif.rsp_rdata), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_ctrl", 32'(ctrl), 32'd0);
    chk("rst_data_z", 32'(data), 32'hFF);
    rst = 1'b0;
    step();

    // Directed vectors with hand-computed expectations.
    for (int i = 0; i < 9; i++) begin
      predict(tbl[i].we, tbl[i].a, tbl[i].wd, e_err, lat, e_rd);
      run_txn(tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].err,
              tbl[i].lat, tbl[i].rd, 1'b0, 1'b0, 16'h0, 8'h0);
    end

    // Back-to-back stores with request held high.
    predict(1'b1, 16'h0001, 8'h21, e_err, lat, e_rd);
    run_txn(1'b1, 16'h0001, 8'h21, e_err, lat, e_rd,
            1'b1, 1'b1, 16'h0002, 8'h42);
    predict(1'b1, 16'h0002, 8'h42, e_err, lat, e_rd);
    run_txn(1'b1, 16'h0002, 8'h42, e_err, lat, e_rd,
            1'b0, 1'b0, 16'h0, 8'h0);
    model_txn(1'b0, 16'h0001, 8'h00);
    model_txn(1'b0, 16'h0002, 8'h00);

    // Random traffic against the reference model.
    for (int n = 0; n < 30; n++) begin
      rwe = 1'($urandom_range(0, 1));
      rwd = 8'($urandom_range(0, 254));
      ra  = 16'($urandom);
      case ($urandom_range(0, 2))
        0: if (ra[15:8] == 8'hFF) ra[15:8] = 8'h00;
        1: ra = {8'hFF, 4'($urandom_range(0, DC - 1)), ra[3:0]};
        default: ra[15:8] = 8'hFF;
      endcase
      model_txn(rwe, ra, rwd);
    end

    // Reset in cycle 50 of a peripheral store.
    chk("rst_mid_ready", 32'(bif.req_ready), 32'd1);
    bif.req_valid = 1'b1;
    bif.req_we    = 1'b1;
    bif.req_addr  = 16'hFF10;
    bif.req_wdata = 8'h6B;
    step();
    bif.req_valid = 1'b0;
    for (int c = 1; c < 50; c++) begin
      chk("rst_mid_ctrl", 32'(ctrl), 32'd1);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_data_z", 32'(data), 32'hFF);
    chk("rst_mid_ctrl0", 32'(ctrl), 32'd0);
    chk("rst_mid_ready1", 32'(bif.req_ready), 32'd1);
    chk("rst_mid_rsp_rdata", 32'(bif.rsp_rdata), 32'd0);
    pulses = 0;
    for (int c = 0; c < 220; c++) begin
      if (bif.rsp_valid) pulses++;
      step();
    end
    chk("rst_mid_no_rsp", 32'(pulses), 32'd0);
    last_rdata = 8'h00;
    last_addr  = 16'h0000;
    model_txn(1'b0, 16'h0010, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_master.md
# bus_master

- Single-outstanding bus master that turns CPU load/store requests into transactions on the shared peripheral/memory bus.
- Provides a valid/ready request side and a response pulse back to the memory-access stage.
- Drives `addr`, the tristate `data`, and `ctrl`, holding them stable for a region-dependent number of wait cycles. Peripherals run from the divided device clock, so they need a longer access window than main memory.

## Interface
Parameters:
- `ADDR_W`, 16: address width.
- `DATA_W`, 8: data width.
- `MEM_WAIT`, 2: ACCESS cycles for main memory (addr[15:8] != 8'hFF). Legal range 1..1023.
- `DEV_WAIT`, 200: ACCESS cycles for peripherals (addr[15:8] == 8'hFF). Legal range 1..1023.
- `DEV_COUNT`, 6: number of mapped peripheral slots at addr[7:4] = 0..DEV_COUNT-1.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: master can accept a request.
- `req_we`, in, 1: 1 = store, 0 = load.
- `req_addr`, in, ADDR_W: transaction address.
- `req_wdata`, in, DATA_W: store data.
- `rsp_valid`, out, 1: one-cycle completion pulse.
- `rsp_rdata`, out, DATA_W: load data. Valid with rsp_valid.
- `rsp_err`, out, 1: unmapped peripheral address. Valid with rsp_valid.
- `addr`, out, ADDR_W: bus address.
- `data`, inout, DATA_W: shared bus data. Driven only during store SETUP/ACCESS; Z otherwise.
- `ctrl`, out, 1: bus direction, 1 = write, 0 = read.

## Operation
States:
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, latch we/addr/wdata.
  - Decode the address: if addr[15:8]==8'hFF and addr[7:4] >= DEV_COUNT, go to DONE with err.
  - Otherwise go to SETUP.
- SETUP (1 cycle):
  - addr = latched address; ctrl = we; data driven with wdata if we.
  - Load wait counter with MEM_WAIT-1 or DEV_WAIT-1 by region.
  - Go to ACCESS.
- ACCESS:
  - All bus outputs held stable.
  - While counter != 0, decrement.
  - When counter == 0 and the load is a read, capture data into rsp_rdata. Go to DONE.
- DONE (1 cycle):
  - rsp_valid = 1; data released to Z; ctrl = 0.
  - Go to IDLE.

Rules:
- Counter is 10 bits and never wraps. Load value is always ≤ 1022.
- Error path: no bus cycle is generated; addr and ctrl are unchanged; rsp_err = 1; rsp_rdata = 0.
- Stores: rsp_rdata keeps its previous value. Consumer ignores it.
- No response backpressure: the consumer must take rsp_valid in its cycle.
- req_ready = 0 in SETUP, ACCESS and DONE. Requests presented then are not accepted and must be held by the requester.
- addr holds its last value after completion; it is not cleared.

## Timing
Reset values (rst high at a rising edge):
- State IDLE.
- req_ready = 1, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0.
- addr = 0, ctrl = 0, data = Z.

Cycle numbering, accept edge = cycle 0:
- SETUP in cycle 1, ACCESS in cycles 2..W+1, DONE/rsp_valid in cycle W+2, next accept possible at cycle W+3.
- W = MEM_WAIT or DEV_WAIT.
- Load data is sampled at the end of cycle W+1 and is visible with rsp_valid.
- Error path: rsp_valid in cycle 1, next accept at cycle 2.

Turnaround and ordering:
- data goes Z in DONE, so two consecutive stores have at least 1 undriven cycle between them.
- ctrl rises only with SETUP and falls in DONE. The bus never sees ctrl = 1 with a changing addr.

Reset during a transaction:
- Abort immediately: IDLE, data Z, ctrl 0, no rsp_valid for the aborted request.

## Test plan
- **Memory load.** MEM_WAIT=2. Preload RAM 0x0010 = 0xA5. Request load 0x0010 at cycle 0. Expect:
  - addr = 0x0010 and ctrl = 0 in cycles 1–3.
  - rsp_valid only in cycle 4, with rsp_rdata = 0xA5 and rsp_err = 0.
- **Peripheral store.** DEV_WAIT=200. Store 0x3C to 0xFF00 (LED). Expect:
  - ctrl = 1 and data = 0x3C stable for cycles 1–201.
  - data Z and rsp_valid in cycle 202.
  - LED register reads back 0x3C.
- **Unmapped address.** Load 0xFF70. Expect:
  - rsp_valid in cycle 1 with rsp_err = 1 and rsp_rdata = 0.
  - addr and ctrl unchanged; no data drive.
- **Back-to-back stores.** Hold req_valid high for stores 0x0001 and 0x0002. Expect:
  - Second accept exactly at cycle W+3.
  - data Z for at least 1 cycle between the two drives.
  - req_ready = 0 in cycles 1..W+2.
- **Reset mid-access.** Assert rst in cycle 50 of a DEV_WAIT store. Expect:
  - From cycle 51: data Z, ctrl 0, req_ready 1.
  - No rsp_valid.
  - A fresh memory load then completes normally.
